// File: rtl/branch_history_table.sv
// Direct-mapped table of saturating counters for branch direction prediction.
// Optional macro BHT_BYPASS_EN: same-cycle same-index lookup sees the updated counter.
module branch_history_table #(
    parameter int PC_WIDTH      = 32,
    parameter int INDEX_BITS    = 6,
    parameter int COUNTER_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_predict_valid,
    input  logic [PC_WIDTH-1:0]      i_predict_pc,
    input  logic                     i_predict_hold,
    output logic                     o_pred_valid,
    output logic                     o_pred_taken,
    output logic [COUNTER_WIDTH-1:0] o_pred_counter,
    input  logic                     i_update_valid,
    input  logic [PC_WIDTH-1:0]      i_update_pc,
    input  logic                     i_update_taken
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [COUNTER_WIDTH-1:0] INIT =
        COUNTER_WIDTH'((1 << (COUNTER_WIDTH - 1)) - 1);
    localparam logic [COUNTER_WIDTH-1:0] CMAX = '1;

    logic [COUNTER_WIDTH-1:0] r_table [ENTRIES];
    logic                     r_pred_valid;
    logic                     r_pred_taken;
    logic [COUNTER_WIDTH-1:0] r_pred_counter;

    logic [INDEX_BITS-1:0]    w_pred_idx;
    logic [INDEX_BITS-1:0]    w_upd_idx;
    logic [COUNTER_WIDTH-1:0] w_upd_old;
    logic [COUNTER_WIDTH-1:0] w_upd_new;
    logic [COUNTER_WIDTH-1:0] w_lookup_val;
    logic                     w_lookup;
    logic                     w_unused;

    assign w_pred_idx = i_predict_pc[INDEX_BITS+1:2];
    assign w_upd_idx  = i_update_pc[INDEX_BITS+1:2];
    assign w_unused   = ^{i_predict_pc[1:0], i_update_pc[1:0],
                          i_predict_pc[PC_WIDTH-1:INDEX_BITS+2],
                          i_update_pc[PC_WIDTH-1:INDEX_BITS+2]};

    assign w_upd_old = r_table[w_upd_idx];

    always_comb begin
        w_upd_new = w_upd_old;
        if (i_update_taken) begin
            if (w_upd_old != CMAX)
                w_upd_new = w_upd_old + COUNTER_WIDTH'(1);
        end else begin
            if (w_upd_old != '0)
                w_upd_new = w_upd_old - COUNTER_WIDTH'(1);
        end
    end

`ifdef BHT_BYPASS_EN
    // Forward the in-flight update so the lookup sees the committed value
    assign w_lookup_val = (i_update_valid && (w_upd_idx == w_pred_idx))
                        ? w_upd_new : r_table[w_pred_idx];
`else
    assign w_lookup_val = r_table[w_pred_idx];
`endif

    assign w_lookup = i_predict_valid && !i_predict_hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++)
                r_table[i] <= INIT;
        end else if (i_update_valid) begin
            r_table[w_upd_idx] <= w_upd_new;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pred_valid   <= 1'b0;
            r_pred_taken   <= 1'b0;
            r_pred_counter <= INIT;
        end else if (!i_predict_hold) begin
            r_pred_valid <= i_predict_valid;
            if (w_lookup) begin
                r_pred_counter <= w_lookup_val;
                r_pred_taken   <= w_lookup_val[COUNTER_WIDTH-1];
            end
        end
    end

    assign o_pred_valid   = r_pred_valid;
    assign o_pred_taken   = r_pred_taken;
    assign o_pred_counter = r_pred_counter;

endmodule

// File: tb/tb_branch_history_table.sv
// Directed-vector bench for branch_history_table; honours BHT_BYPASS_EN.
module tb_branch_history_table;

    logic        clk;
    logic        reset;
    logic        predict_valid;
    logic [31:0] predict_pc;
    logic        predict_hold;
    logic        pred_valid;
    logic        pred_taken;
    logic [1:0]  pred_counter;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;

    int n_vec;
    int n_bad;

    branch_history_table dut (
        .clk            (clk),
        .reset          (reset),
        .i_predict_valid(predict_valid),
        .i_predict_pc   (predict_pc),
        .i_predict_hold (predict_hold),
        .o_pred_valid   (pred_valid),
        .o_pred_taken   (pred_taken),
        .o_pred_counter (pred_counter),
        .i_update_valid (update_valid),
        .i_update_pc    (update_pc),
        .i_update_taken (update_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        predict_valid = 1'b0;
        predict_hold  = 1'b0;
        update_valid  = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        idle();
        predict_valid = 1'b1;
        predict_pc    = pc;
        step();
        idle();
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk);
        idle();
        update_valid = 1'b1;
        update_pc    = pc;
        update_taken = tk;
        step();
        idle();
    endtask

    task automatic expect_pred(input string tag, input logic v,
                               input logic t, input logic [1:0] c);
        check({tag, ".valid"}, 32'(pred_valid), 32'(v));
        check({tag, ".taken"}, 32'(pred_taken), 32'(t));
        check({tag, ".ctr"}, 32'(pred_counter), 32'(c));
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        predict_pc = '0;
        update_pc = '0;
        update_taken = 1'b0;
        idle();
        repeat (2) step();
        expect_pred("reset", 1'b0, 1'b0, 2'd1);
        reset = 1'b0;

        lookup(32'h100);
        expect_pred("init_lookup", 1'b1, 1'b0, 2'd1);
        step();
        expect_pred("idle_drop", 1'b0, 1'b0, 2'd1);

        upd(32'h100, 1'b1);
        upd(32'h100, 1'b1);
        lookup(32'h100);
        expect_pred("inc_to3", 1'b1, 1'b1, 2'd3);
        upd(32'h100, 1'b1);
        lookup(32'h100);
        expect_pred("sat_hi", 1'b1, 1'b1, 2'd3);

        // Hold with a new lookup pending; an update still lands underneath
        predict_hold  = 1'b1;
        predict_valid = 1'b1;
        predict_pc    = 32'h104;
        update_valid  = 1'b1;
        update_pc     = 32'h104;
        update_taken  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            update_valid = 1'b0;
            expect_pred($sformatf("hold%0d", i), 1'b1, 1'b1, 2'd3);
        end
        lookup(32'h104);
        expect_pred("upd_in_hold", 1'b1, 1'b0, 2'd0);
        lookup(32'h100);
        expect_pred("pre_reset", 1'b1, 1'b1, 2'd3);

        #2 reset = 1'b1;
        #1;
        expect_pred("async_reset", 1'b0, 1'b0, 2'd1);
        #1 reset = 1'b0;
        lookup(32'h100);
        expect_pred("post_reset", 1'b1, 1'b0, 2'd1);

        upd(32'h104, 1'b0);
        lookup(32'h104);
        expect_pred("dec_to0", 1'b1, 1'b0, 2'd0);
        upd(32'h104, 1'b0);
        lookup(32'h104);
        expect_pred("sat_lo", 1'b1, 1'b0, 2'd0);

        upd(32'h200, 1'b1);
        lookup(32'h100);
        expect_pred("alias", 1'b1, 1'b1, 2'd2);
        lookup(32'h102);
        expect_pred("low_bits", 1'b1, 1'b1, 2'd2);

        idle();
        predict_valid = 1'b1;
        predict_pc    = 32'h108;
        update_valid  = 1'b1;
        update_pc     = 32'h108;
        update_taken  = 1'b1;
        step();
        idle();
`ifdef BHT_BYPASS_EN
        expect_pred("same_idx", 1'b1, 1'b1, 2'd2);
`else
        expect_pred("same_idx", 1'b1, 1'b0, 2'd1);
`endif
        lookup(32'h108);
        expect_pred("same_idx_next", 1'b1, 1'b1, 2'd2);

        predict_valid = 1'b1;
        predict_pc    = 32'h10C;
        update_valid  = 1'b1;
        update_pc     = 32'h104;
        update_taken  = 1'b1;
        step();
        idle();
        expect_pred("diff_idx", 1'b1, 1'b0, 2'd1);
        lookup(32'h104);
        expect_pred("diff_idx_upd", 1'b1, 1'b0, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
